// File: rtl/somador_serial_param.sv
// Serial WIDTH-bit adder: A+B+cin, STEP bits per clock, with a start/busy/valid handshake.
// ACTIVE_LOW_INPUTS_EN: invert a, b and cin as they are latched.
module somador_serial_param #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             valid
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_param_check
    $error("somador_serial_param: WIDTH must be >= 2 and a multiple of STEP");
  end

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, s_q, s_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, ovf_q, busy_q, valid_q;

  logic [WIDTH-1:0] a_in, b_in;
  logic             cin_in;

`ifdef ACTIVE_LOW_INPUTS_EN
  assign a_in   = ~a;
  assign b_in   = ~b;
  assign cin_in = ~cin;
`else
  assign a_in   = a;
  assign b_in   = b;
  assign cin_in = cin;
`endif

  logic [STEP-1:0] a_sl, b_sl, sum_sl;
  logic            c_sl, c_msb_in, last;

  // One STEP-bit full-adder slice; the slice index walks LSB to MSB.
  always_comb begin
    a_sl              = a_q[int'(cnt_q)*STEP +: STEP];
    b_sl              = b_q[int'(cnt_q)*STEP +: STEP];
    {c_sl, sum_sl}    = {1'b0, a_sl} + {1'b0, b_sl} + {{STEP{1'b0}}, carry_q};
    c_msb_in          = a_sl[STEP-1] ^ b_sl[STEP-1] ^ sum_sl[STEP-1];
    last              = (cnt_q == CW'(N-1));
    s_d               = s_q;
    s_d[int'(cnt_q)*STEP +: STEP] = sum_sl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            carry_q <= cin_in;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            state_q <= ADD;
          end
        end
        ADD: begin
          s_q     <= s_d;
          carry_q <= c_sl;
          if (last) begin
            // Overflow: carry into the MSB differs from carry out of it.
            cout_q  <= c_sl;
            ovf_q   <= c_msb_in ^ c_sl;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s     = s_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;
  assign busy  = busy_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_somador_serial_param.sv
// Scoreboard bench for somador_serial_param: STEP=1, 4 and 8 instances on WIDTH=8.
module tb_somador_serial_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start [3];
  logic [7:0] a     [3];
  logic [7:0] b     [3];
  logic       cin   [3];
  logic [7:0] s     [3];
  logic       cout  [3];
  logic       ovf   [3];
  logic       busy  [3];
  logic       valid [3];

  int nstep [3] = '{8, 2, 1};

  somador_serial_param #(.WIDTH(8), .STEP(1)) u_step1 (
    .clk(clk), .rst(rst), .start(start[0]), .a(a[0]), .b(b[0]), .cin(cin[0]),
    .s(s[0]), .cout(cout[0]), .ovf(ovf[0]), .busy(busy[0]), .valid(valid[0]));

  somador_serial_param #(.WIDTH(8), .STEP(4)) u_step4 (
    .clk(clk), .rst(rst), .start(start[1]), .a(a[1]), .b(b[1]), .cin(cin[1]),
    .s(s[1]), .cout(cout[1]), .ovf(ovf[1]), .busy(busy[1]), .valid(valid[1]));

  somador_serial_param #(.WIDTH(8), .STEP(8)) u_step8 (
    .clk(clk), .rst(rst), .start(start[2]), .a(a[2]), .b(b[2]), .cin(cin[2]),
    .s(s[2]), .cout(cout[2]), .ovf(ovf[2]), .busy(busy[2]), .valid(valid[2]));

  typedef struct packed {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t sb [$];
  exp_t last_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    logic [7:0] ea, eb;
    logic       ec;
    logic [8:0] t;
    exp_t       r;
`ifdef ACTIVE_LOW_INPUTS_EN
    ea = ~av; eb = ~bv; ec = ~cv;
`else
    ea = av;  eb = bv;  ec = cv;
`endif
    t      = {1'b0, ea} + {1'b0, eb} + {8'd0, ec};
    r.s    = t[7:0];
    r.cout = t[8];
    r.ovf  = (ea[7] == eb[7]) && (t[7] != ea[7]);
    return r;
  endfunction

  // Starts one op on instance k from a negedge; inj injects a stray start at that
  // ADD cycle, rst_at pulses reset at that ADD cycle (-1 disables either).
  task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input int inj, input int rst_at);
    int   n;
    exp_t e;
    a[k] = av; b[k] = bv; cin[k] = cv; start[k] = 1'b1;
    sb.push_back(model(av, bv, cv));
    @(negedge clk);
    start[k] = 1'b0;
    a[k] = 8'($urandom); b[k] = 8'($urandom); cin[k] = 1'($urandom);
    check("busy_on_accept", 32'(busy[k]), 32'd1);
    check("valid_on_accept", 32'(valid[k]), 32'd0);
    check("s_cleared", 32'(s[k]), 32'd0);
    n = 0;
    while (!valid[k] && n < 40) begin
      if (n == inj) begin start[k] = 1'b1; a[k] = 8'h00; b[k] = 8'h00; end
      if (n == rst_at) rst = 1'b1;
      @(negedge clk);
      n++;
      start[k] = 1'b0;
      if (rst) begin
        rst = 1'b0;
        check("rst_busy", 32'(busy[k]), 32'd0);
        check("rst_valid", 32'(valid[k]), 32'd0);
        check("rst_s", 32'(s[k]), 32'd0);
        void'(sb.pop_back());
        return;
      end
    end
    check("latency", 32'(n), 32'(nstep[k]));
    check("busy_done", 32'(busy[k]), 32'd0);
    e = sb.pop_front();
    last_e = e;
    check("sum", 32'(s[k]), 32'(e.s));
    check("cout", 32'(cout[k]), 32'(e.cout));
    check("ovf", 32'(ovf[k]), 32'(e.ovf));
  endtask

  task automatic hold(input int k, input int cycles);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid[k] !== 1'b1 || busy[k] !== 1'b0 || s[k] !== last_e.s ||
          cout[k] !== last_e.cout || ovf[k] !== last_e.ovf) bad++;
    end
    check("hold_stable", 32'(bad), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0; a[k] = 8'h00; b[k] = 8'h00; cin[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_busy", 32'(busy[k]), 32'd0);
      check("reset_valid", 32'(valid[k]), 32'd0);
      check("reset_s", 32'(s[k]), 32'd0);
      check("reset_cout", 32'(cout[k]), 32'd0);
      check("reset_ovf", 32'(ovf[k]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_op(0, 8'h5A, 8'h3C, 1'b0, -1, -1);
    run_op(0, 8'hFF, 8'h01, 1'b1, -1, -1);
    hold(0, 20);
    run_op(0, 8'h12, 8'h34, 1'b0, 3, -1);
    hold(0, 3);
    run_op(0, 8'h77, 8'h11, 1'b1, -1, 4);
    check("idle_after_rst", 32'(valid[0]), 32'd0);
    run_op(0, 8'h80, 8'h80, 1'b0, -1, -1);
    run_op(0, 8'h7F, 8'h7F, 1'b1, -1, -1);

    run_op(1, 8'h7F, 8'h01, 1'b0, -1, -1);
    run_op(1, 8'h0F, 8'hF0, 1'b1, 1, -1);
    hold(1, 4);
    run_op(2, 8'hFF, 8'hFE, 1'b1, -1, -1);
    hold(2, 4);
    run_op(2, 8'h40, 8'h40, 1'b0, -1, -1);

    for (int i = 0; i < 12; i++) begin
      run_op(i % 3, 8'($urandom), 8'($urandom), 1'($urandom), -1, -1);
    end
    if (sb.size() != 0) check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
